// File: rtl/knn_dist_calc.sv
// Squared-Euclidean distance stage feeding the KNN sorted neighbour list.
// Optional saturation of out-of-range distances: define KNN_DIST_SAT_EN.
module knn_dist_calc #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] test_x,
  input  logic signed [COORD_W-1:0] test_y,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  input  logic        [LABEL_W-1:0] in_label,
  input  logic                      in_last,
  output logic                      dist_valid,
  output logic        [DATA_W-1:0]  dist_out,
  output logic        [LABEL_W-1:0] label_out,
  output logic                      busy,
  output logic                      done,
  output logic        [CNT_W-1:0]   point_cnt
);

  localparam int unsigned DIFF_W = COORD_W + 1;
  localparam int unsigned SQ_W   = 2 * COORD_W + 2;
  localparam int unsigned SUM_W  = 2 * COORD_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [COORD_W-1:0] test_x_q;
  logic signed [COORD_W-1:0] test_y_q;

  logic                     s1_v;
  logic signed [DIFF_W-1:0] s1_dx;
  logic signed [DIFF_W-1:0] s1_dy;
  logic        [LABEL_W-1:0] s1_label;

  logic                s2_v;
  logic [SQ_W-1:0]     s2_sx;
  logic [SQ_W-1:0]     s2_sy;
  logic [LABEL_W-1:0]  s2_label;

  logic [SUM_W-1:0]    sum_c;
  logic [DATA_W-1:0]   dist_c;
  logic                accept_c;

  assign accept_c = in_valid & in_ready;

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept_c && in_last) state_next = DRAIN;
      // s3 empties on this edge once s1/s2 are empty, so done lands right after the final result
      DRAIN:   if (!s1_v && !s2_v) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == RUN);
      busy     <= (state_next == RUN) || (state_next == DRAIN);
      done     <= (state_next == DONE);
    end
  end

  // Test point latch and saturating accepted-point counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_x_q  <= '0;
      test_y_q  <= '0;
      point_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      test_x_q  <= test_x;
      test_y_q  <= test_y;
      point_cnt <= '0;
    end else if (accept_c && (point_cnt != {CNT_W{1'b1}})) begin
      point_cnt <= point_cnt + CNT_W'(1);
    end
  end

  // S1: coordinate differences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_label <= '0;
    end else begin
      s1_v <= accept_c;
      if (accept_c) begin
        s1_dx    <= DIFF_W'(in_x) - DIFF_W'(test_x_q);
        s1_dy    <= DIFF_W'(in_y) - DIFF_W'(test_y_q);
        s1_label <= in_label;
      end
    end
  end

  // S2: squares, computed at full signed width so the result is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_sx    <= '0;
      s2_sy    <= '0;
      s2_label <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sx    <= $unsigned(SQ_W'(s1_dx) * SQ_W'(s1_dx));
        s2_sy    <= $unsigned(SQ_W'(s1_dy) * SQ_W'(s1_dy));
        s2_label <= s1_label;
      end
    end
  end

  assign sum_c = SUM_W'(s2_sx) + SUM_W'(s2_sy);

  // Reduce the full-precision sum to the output width.
  generate
    if (SUM_W > DATA_W) begin : g_reduce
`ifdef KNN_DIST_SAT_EN
      assign dist_c = (|sum_c[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum_c[DATA_W-1:0];
`else
      assign dist_c = sum_c[DATA_W-1:0];
`endif
    end else begin : g_extend
      assign dist_c = DATA_W'(sum_c);
    end
  endgenerate

  // S3: result register; holds last value between valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_valid <= 1'b0;
      dist_out   <= '0;
      label_out  <= '0;
    end else begin
      dist_valid <= s2_v;
      if (s2_v) begin
        dist_out  <= dist_c;
        label_out <= s2_label;
      end
    end
  end

endmodule
